// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
// Shared definitions for the configuration-chain loader:
//   - state_t   : loader FSM states
//   - CRC8_POLY : CRC-8 polynomial x^8+x^2+x+1 (0x07, x^8 implicit)
//   - CRC8_INIT : CRC-8 initial value
//   - crc8_step : one serial CRC-8 update (MSB-out shift register form)
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// ccff_crc8_serial
// Bit-serial CRC-8 accumulator (polynomial and init value from ccff_loader_pkg).
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset (CRC returns to init value)
//   i_clr   : synchronous clear back to the init value (wins over i_en)
//   i_en    : fold i_bit into the CRC this cycle
//   i_bit   : serial data bit
//   o_crc   : current CRC value
module ccff_crc8_serial
    import ccff_loader_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= CRC8_INIT;
        end else if (i_clr) begin
            r_crc <= CRC8_INIT;
        end else if (i_en) begin
            r_crc <= crc8_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Streams a bitstream, delivered as WORD_W-bit words over a valid/ready
// handshake, LSB first into a CHAIN_LEN-bit configuration flip-flop chain.
// One chain bit is shifted per cycle in which ccff_shift_en is high (that
// signal enables the external prog_clk gate). A CRC-8 is taken over every
// bit shifted in.
//
// Optional feature (macro CCFF_READBACK_CHECK_EN): after loading, the chain
// is clocked CHAIN_LEN more times with its tail fed back to its head, which
// restores the contents, while a second CRC-8 is taken over the tail bits;
// crc_err reports a mismatch between the two CRCs. Without the macro there
// is no VERIFY phase and crc_err is tied 0.
//
// Ports:
//   prog_clk      : clock
//   prog_reset_n  : asynchronous active-low reset
//   start         : load request (honoured only in IDLE/DONE)
//   bs_data       : bitstream word
//   bs_valid      : bs_data is valid
//   bs_ready      : loader can take a word this cycle
//   ccff_head     : serial data into chain head
//   ccff_tail     : serial data from chain tail
//   ccff_shift_en : chain shift enable
//   busy          : LOAD or VERIFY in progress
//   done          : load finished (DONE state)
//   crc_err       : readback CRC differed from load CRC
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 30,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BCNT_W = $clog2(WORD_W + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_acc_bits;   // chain bits accepted so far
    logic [CNT_W-1:0]    r_shift_cnt;  // shifts issued (LOAD) / recirculations (VERIFY)
    logic [WORD_W-1:0]   r_buf;
    logic [BCNT_W-1:0]   r_buf_cnt;    // bits still to emit from r_buf
    logic                r_head;
    logic                r_shift_en;

    logic                w_start_ok;
    logic                w_in_load;
    logic                w_ready;
    logic                w_accept;
    logic                w_emit;
    logic                w_emit_bit;
    logic [CNT_W-1:0]    w_remain;
    logic [BCNT_W-1:0]   w_take;
    logic [7:0]          w_crc_load;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_in_load  = (r_state == ST_LOAD);

    // Refill while the buffer is empty or on its last bit, so a continuous
    // stream never leaves a gap between words.
    assign w_ready  = w_in_load && (r_acc_bits < CNT_W'(CHAIN_LEN)) && (r_buf_cnt <= BCNT_W'(1));
    assign w_accept = w_ready && bs_valid;

    // An empty buffer forwards bit 0 of the word being accepted straight to
    // the output register; otherwise the buffer's LSB goes out.
    assign w_emit     = w_in_load && ((r_buf_cnt != '0) || w_accept);
    assign w_emit_bit = (r_buf_cnt != '0) ? r_buf[0] : bs_data[0];

    // Only the bits still needed by the chain count from the final word.
    assign w_remain = CNT_W'(CHAIN_LEN) - r_acc_bits;
    assign w_take   = (32'(w_remain) >= 32'(WORD_W)) ? BCNT_W'(WORD_W) : BCNT_W'(w_remain);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                // r_shift_cnt reaches CHAIN_LEN in the cycle the last bit shifts.
                if (r_shift_cnt == CNT_W'(CHAIN_LEN)) begin
`ifdef CCFF_READBACK_CHECK_EN
                    w_state_nxt = ST_VERIFY;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
`ifdef CCFF_READBACK_CHECK_EN
            ST_VERIFY: begin
                if (r_shift_cnt == CNT_W'(CHAIN_LEN - 1)) w_state_nxt = ST_DONE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_acc_bits  <= '0;
            r_buf_cnt   <= '0;
            r_shift_cnt <= '0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
        end else begin
            r_shift_en <= w_emit;
            if (w_emit) r_head <= w_emit_bit;

            if (w_start_ok) begin
                r_acc_bits <= '0;
                r_buf_cnt  <= '0;
            end else if (w_accept) begin
                r_acc_bits <= r_acc_bits + CNT_W'(w_take);
                // Buffer held its last bit (emitted now): keep the whole word.
                // Buffer was empty: bit 0 is emitted now, keep the rest.
                r_buf_cnt  <= (r_buf_cnt != '0) ? w_take : (w_take - BCNT_W'(1));
            end else if (r_buf_cnt != '0) begin
                r_buf_cnt <= r_buf_cnt - BCNT_W'(1);
            end

            if (w_start_ok) begin
                r_shift_cnt <= '0;
            end else if (w_emit) begin
                r_shift_cnt <= r_shift_cnt + CNT_W'(1);
            end
`ifdef CCFF_READBACK_CHECK_EN
            else if (w_in_load && (w_state_nxt == ST_VERIFY)) begin
                r_shift_cnt <= '0;
            end else if (r_state == ST_VERIFY) begin
                r_shift_cnt <= r_shift_cnt + CNT_W'(1);
            end
`endif
        end
    end

    // Word buffer is pure data; r_buf_cnt says which of its bits are live.
    always_ff @(posedge prog_clk) begin
        if (w_accept) begin
            r_buf <= (r_buf_cnt != '0) ? bs_data : (bs_data >> 1);
        end else if (r_buf_cnt != '0) begin
            r_buf <= r_buf >> 1;
        end
    end

    ccff_crc8_serial u_crc_load (
        .i_clk   (prog_clk),
        .i_rst_n (prog_reset_n),
        .i_clr   (w_start_ok),
        .i_en    (w_emit),
        .i_bit   (w_emit_bit),
        .o_crc   (w_crc_load)
    );

`ifdef CCFF_READBACK_CHECK_EN
    logic [7:0] w_crc_rb;
    logic       w_in_verify;

    assign w_in_verify = (r_state == ST_VERIFY);

    ccff_crc8_serial u_crc_readback (
        .i_clk   (prog_clk),
        .i_rst_n (prog_reset_n),
        .i_clr   (w_start_ok),
        .i_en    (w_in_verify),
        .i_bit   (ccff_tail),
        .o_crc   (w_crc_rb)
    );

    // Recirculation: tail feeds head so the chain ends up unchanged.
    assign ccff_head     = w_in_verify ? ccff_tail : r_head;
    assign ccff_shift_en = w_in_verify | r_shift_en;
    assign crc_err       = (r_state == ST_DONE) && (w_crc_load != w_crc_rb);
`else
    logic [8:0] w_unused_crc;
    assign w_unused_crc  = {w_crc_load, ccff_tail};
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign crc_err       = 1'b0;
`endif

    assign bs_ready = w_ready;
    assign busy     = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
    assign done     = (r_state == ST_DONE);

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 30, giving the configuration chain length in bits (10 size-6 mux memories x 3 bits).
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream word width.
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port prog_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle load request.
REQ-006 SHALL have port bs_data, input, WORD_W bits: bitstream word.
REQ-007 SHALL have ports bs_valid (input) and bs_ready (output), 1 bit each: word handshake.
REQ-008 SHALL have port ccff_head, output, 1 bit: serial data into the chain head.
REQ-009 SHALL have port ccff_tail, input, 1 bit: serial data from the chain tail.
REQ-010 SHALL have port ccff_shift_en, output, 1 bit: enable for the external prog_clk gate; the chain shifts one bit per cycle in which it is 1.
REQ-011 SHALL have ports busy, done and crc_err, outputs, 1 bit each: status.

Function
REQ-012 States SHALL be IDLE, LOAD, VERIFY and DONE.
- IDLE and DONE: start moves to LOAD, clears done, crc_err, bit counter and CRC.
- start SHALL be ignored in LOAD and VERIFY.
REQ-013 busy SHALL be 1 exactly in LOAD and VERIFY; done SHALL be 1 exactly in DONE.
REQ-014 Word handshake:
- A word is accepted on bs_valid && bs_ready.
- bs_ready SHALL be 1 in LOAD while bits remain unaccepted and the word buffer is empty or emitting its final bit this cycle.
- With bs_valid held high, the stream SHALL have no bubble.
REQ-015 Serialisation:
- Bits are sent LSB first, one per cycle, from a buffered word.
- ccff_head and ccff_shift_en SHALL be registered together.
- The first shift occurs the cycle after the first accept.
REQ-016 Starvation: when the buffer is empty and no word is accepted, ccff_shift_en SHALL be 0 and ccff_head SHALL hold its value; no bit is lost or duplicated.
REQ-017 Exactly CHAIN_LEN shifts SHALL occur per load.
- Bits of the final word beyond CHAIN_LEN SHALL be discarded.
- Total words accepted SHALL equal ceil(CHAIN_LEN/WORD_W).
REQ-018 After the CHAIN_LEN-th shift, the block SHALL enter VERIFY if configured (REQ-022), else DONE in the next cycle.
REQ-019 A serial CRC-8 (polynomial x^8+x^2+x+1, init 0xFF) SHALL be updated with each bit shifted in LOAD.

Reset
REQ-020 On prog_reset_n low, the block SHALL asynchronously reach IDLE with these outputs 0: ccff_head, ccff_shift_en, bs_ready, busy, done, crc_err.
REQ-021 Reset mid-load SHALL abandon the load; chain contents are then undefined and the next start reloads all CHAIN_LEN bits.

Configuration
REQ-022 Macro CCFF_READBACK_CHECK_EN:
- Defined: VERIFY runs CHAIN_LEN cycles with ccff_shift_en=1, ccff_head combinationally equal to ccff_tail (recirculation restores the contents), and a second CRC computed over ccff_tail.
- VERIFY then goes to DONE, with crc_err=1 if the two CRCs differ.
- Undefined: no VERIFY state, no second CRC, crc_err tied 0.

Structure
REQ-023 Package ccff_loader_pkg SHALL hold the state enum, CRC polynomial and CRC init constants.
REQ-024 Sub-module ccff_crc8_serial (bit in, enable, clear, 8-bit CRC out) SHALL be instantiated once for the load CRC and once more under CCFF_READBACK_CHECK_EN.

Verification (CHAIN_LEN=30, WORD_W=8, behavioural 30-bit chain model)
REQ-025 Continuous stream:
- Stimulus: 0xA5, 0x3C, 0xFF, 0x12 with bs_valid always high.
- Response: 30 contiguous ccff_shift_en cycles; ccff_head starts 1,0,1,0,0,1,0,1; 2 MSBs of 0x12 dropped; model content matches.
REQ-026 Starvation:
- Stimulus: bs_valid low for 3 cycles between words 2 and 3.
- Response: ccff_shift_en low exactly 3 cycles; final model content identical to REQ-025.
REQ-027 start pulsed during LOAD -> ignored; exactly 30 shifts and 4 accepts.
REQ-028 Reset mid-load:
- Stimulus: prog_reset_n low after the 17th shift, then a new start with the full stream.
- Response: all outputs 0 during reset; 30 fresh shifts; correct content.
REQ-029 With CCFF_READBACK_CHECK_EN:
- Clean chain -> 60 shift cycles total, content preserved, crc_err=0.
- Model bit 12 flipped during VERIFY -> crc_err=1.
- Without the macro -> done one cycle after shift 30, crc_err constant 0.
